serial_parity_rx: RTL and testbench
===================================

# serial_parity_rx

- Receives a serial frame one bit per qualified cycle: start bit, DATA_W data bits LSB first, one parity bit, stop bit.
- Reassembles the data word and checks parity with a running XOR accumulator.
- Reports the word with a one-cycle valid pulse and parity/framing error flags.
- Sits at the receive end of the team's serial parity link, opposite the parity transmitter, and feeds downstream capture or compare logic.

## Interface
Parameters:
- DATA_W, 8, data bits per frame (legal range 1..32)

Ports:
- clk  input  1  single clock; all logic is rising-edge
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- rx_bit  input  1  serial line bit
- rx_valid  input  1  qualifies rx_bit; a bit is consumed only on a cycle with rx_valid=1
- data_out  output  DATA_W  last received word; held until the next completed frame
- data_vld  output  1  one-cycle pulse: a frame completed with a good stop bit
- parity_err  output  1  one-cycle pulse, coincident with data_vld, when parity fails
- frame_err  output  1  one-cycle pulse when the stop bit is 0
- busy  output  1  high while in any state other than IDLE

## Operation
- States: IDLE, DATA, PARITY, STOP.
- IDLE:
  - consumed rx_bit=0 (start): go to DATA; clear bit counter and parity accumulator.
  - consumed rx_bit=1: ignored; stay in IDLE.
- DATA:
  - each consumed bit shifts into the shift register at the MSB side (LSB-first reassembly).
  - each consumed bit is XORed into the accumulator; the counter increments.
  - after the DATA_W-th bit, go to PARITY.
- PARITY: the consumed bit is XORed into the accumulator; go to STOP.
- STOP, consumed rx_bit=1:
  - data_out <= shift register; data_vld=1.
  - parity_err=1 if the accumulator shows a mismatch.
  - go to IDLE.
- STOP, consumed rx_bit=0:
  - frame_err=1; data_vld=0; data_out unchanged; parity_err=0.
  - go to IDLE.
- rx_valid=0 on any cycle: state, counter, accumulator and shift register all hold. Gaps of any length are legal mid-frame.
- Bit counter width: $clog2(DATA_W+1). No wrap is possible because the counter stops at DATA_W.
- No back-to-back overlap: a new start bit is recognised only after STOP returns to IDLE. The earliest new start is the first consumed bit after the stop bit.

## Timing
- Reset values: data_out=0, data_vld=0, parity_err=0, frame_err=0, busy=0, state=IDLE, counter=0, accumulator=0.
- Latency: data_vld, parity_err and frame_err rise in the cycle after the stop bit is consumed, and are high for exactly one cycle.
- data_out updates in the same cycle data_vld rises.
- Minimum frame length is DATA_W+3 consumed bits, so the minimum spacing of data_vld pulses is DATA_W+3 cycles.
- busy rises in the cycle after the start bit is consumed and falls in the cycle after the stop bit is consumed.
- Reset mid-frame (rst_n=0 at a rising edge):
  - all registers return to reset values on that edge; the partial frame is discarded.
  - no error pulse is generated.
  - rst_n has priority over rx_valid.

## Configuration
- Macro: SERIAL_PARITY_RX_ODD_EN.
- Undefined: even parity. The XOR of all data bits and the parity bit must be 0; otherwise parity_err.
- Defined: odd parity. The XOR must be 1; otherwise parity_err.
- The macro changes only the compare constant. Ports and timing are identical in both builds.

## Structure
- Shared package serial_parity_pkg holds:
  - state enum typedef (IDLE, DATA, PARITY, STOP)
  - localparam PARITY_EXPECT, selected by SERIAL_PARITY_RX_ODD_EN
  - frame overhead constant FRAME_OVH=3
- The package is also used by the matching transmitter.
- One sub-module: parity_acc, a 1-bit XOR accumulator with clear and enable inputs, instanced once.

## Test plan
- Reset, then DATA_W=8, even build, frame 0, 0xA5 LSB first, parity 0, stop 1 -> data_out=0xA5, data_vld pulse, parity_err=0, busy low one cycle after stop.
- Same frame with parity bit 1 -> data_vld=1 and parity_err=1 in the same cycle, data_out=0xA5; odd build with parity 1 -> parity_err=0.
- Frame 0x3C with stop bit 0 -> frame_err pulse, data_vld=0, data_out keeps the previous 0xA5.
- Frame 0x81 with rx_valid deasserted for 5 cycles after data bit 3 and 2 cycles before stop -> data_out=0x81, no error; state held during the gaps.
- Mid-DATA rst_n=0 for 1 cycle, then a full frame 0x5A -> no pulse from the aborted frame, data_out=0 until 0x5A completes, then 0x5A.
- Idle line: rx_bit=1 with rx_valid=1 for 20 cycles -> busy=0, no pulses; then two back-to-back frames 0x01, 0xFE -> two data_vld pulses 11 cycles apart.

Source files
------------

// File: rtl/serial_parity_pkg.sv
// ---------------------------------------------------------------------------
// serial_parity_pkg
// Shared definitions for the serial parity link (receiver and transmitter).
//
// Contents:
//   state_t        frame-level state encoding (IDLE, DATA, PARITY, STOP)
//   PARITY_EXPECT  required XOR of data bits + parity bit
//                  (0 = even parity, 1 = odd parity)
//   FRAME_OVH      non-data bits per frame (start + parity + stop)
//   frame_bits()   total consumed bits in one frame for a given data width
//
// Build option:
//   SERIAL_PARITY_RX_ODD_EN  defined -> odd parity, undefined -> even parity
// ---------------------------------------------------------------------------
package serial_parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

`ifdef SERIAL_PARITY_RX_ODD_EN
    localparam logic PARITY_EXPECT = 1'b1;
`else
    localparam logic PARITY_EXPECT = 1'b0;
`endif

    localparam int FRAME_OVH = 3;

    function automatic int frame_bits(input int data_w);
        return data_w + FRAME_OVH;
    endfunction

endpackage

// File: rtl/serial_parity_rx_parity_acc.sv
// ---------------------------------------------------------------------------
// parity_acc
// One-bit running XOR accumulator. A clear wins over an enable in the same
// cycle; with neither asserted the accumulator holds.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset (accumulator -> 0)
//   clr     in   clear accumulator to 0 on the next edge
//   en      in   fold bit_in into the accumulator on the next edge
//   bit_in  in   bit to accumulate
//   acc     out  current accumulator value
// ---------------------------------------------------------------------------
module parity_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic acc
);

    logic acc_q;
    logic acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = 1'b0;
        end else if (en) begin
            acc_d = acc_q ^ bit_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/serial_parity_rx.sv
// ---------------------------------------------------------------------------
// serial_parity_rx
// Serial frame receiver: start bit (0), DATA_W data bits LSB first, one
// parity bit, stop bit (1). One bit is consumed per cycle with rx_valid=1;
// rx_valid=0 freezes the whole receiver, so gaps of any length are legal.
//
// Parameters:
//   DATA_W      data bits per frame (1..32)
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset, priority over rx_valid
//   rx_bit      in   serial line bit
//   rx_valid    in   qualifies rx_bit
//   data_out    out  last good word, held until the next good frame
//   data_vld    out  1-cycle pulse after a frame with a good stop bit
//   parity_err  out  1-cycle pulse alongside data_vld on parity mismatch
//   frame_err   out  1-cycle pulse after a frame whose stop bit was 0
//   busy        out  high whenever the receiver is not in IDLE
//
// Build option:
//   SERIAL_PARITY_RX_ODD_EN  defined -> odd parity, undefined -> even parity
//
// State | Meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a consumed 0 (start bit); consumed 1s are ignored
// DATA  | shifting in data bits, counting up to DATA_W
// PARITY| folding the parity bit into the accumulator
// STOP  | checking the stop bit and publishing the word or a framing error
// ---------------------------------------------------------------------------
module serial_parity_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_bit,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    import serial_parity_pkg::*;

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   shift_in;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                vld_q, vld_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                acc_clr;
    logic                acc_en;
    logic                acc;

    // LSB-first reassembly: each new bit enters at the MSB, so after DATA_W
    // shifts the first bit received has reached bit 0.
    generate
        if (DATA_W == 1) begin : g_shift_1
            assign shift_in = rx_bit;
        end else begin : g_shift_n
            assign shift_in = {rx_bit, shift_q[DATA_W-1:1]};
        end
    endgenerate

    parity_acc u_parity_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (acc_clr),
        .en     (acc_en),
        .bit_in (rx_bit),
        .acc    (acc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        acc_clr = 1'b0;
        acc_en  = 1'b0;

        if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (!rx_bit) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        acc_clr = 1'b1;
                    end
                end
                DATA: begin
                    shift_d = shift_in;
                    acc_en  = 1'b1;
                    cnt_d   = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    acc_en  = 1'b1;
                    state_d = STOP;
                end
                STOP: begin
                    if (rx_bit) begin
                        data_d = shift_q;
                        vld_d  = 1'b1;
                        perr_d = (acc != PARITY_EXPECT);
                    end else begin
                        // Bad stop bit: drop the word, report framing only.
                        ferr_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data_out   = data_q;
    assign data_vld   = vld_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
module tb_serial_parity_rx;

    localparam int DW = 8;

`ifdef SERIAL_PARITY_RX_ODD_EN
    localparam logic PEXP = 1'b1;
`else
    localparam logic PEXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_bit = 1'b1;
    logic          rx_valid = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_vld;
    logic          parity_err;
    logic          frame_err;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int vld_cnt = 0;
    int ferr_cnt = 0;
    int last_vld_cyc = 0;
    int prev_vld_cyc = 0;

    serial_parity_rx #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_bit     (rx_bit),
        .rx_valid   (rx_valid),
        .data_out   (data_out),
        .data_vld   (data_vld),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_vld) begin
            vld_cnt      = vld_cnt + 1;
            prev_vld_cyc = last_vld_cyc;
            last_vld_cyc = cyc;
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
    end

    // Reference rule: XOR of data bits and parity bit must equal PEXP.
    function automatic logic good_parity(input logic [DW-1:0] w);
        return (^w) ^ PEXP;
    endfunction

    task automatic step(input logic v, input logic b);
        rx_valid = v;
        rx_bit   = b;
        @(posedge clk);
        #1;
    endtask

    // Drives one frame; returns after the stop bit edge, with busy ANDed over
    // every cycle between the start bit and the stop bit (gaps included).
    task automatic send_frame(input logic [DW-1:0] w, input logic pbit,
                              input logic sbit, input int gap_after,
                              input int gap_len, input int stop_gap,
                              output logic busy_all);
        busy_all = 1'b1;
        step(1'b1, 1'b0);
        busy_all &= busy;
        for (int i = 0; i < DW; i++) begin
            step(1'b1, w[i]);
            busy_all &= busy;
            if (i == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    step(1'b0, 1'($urandom_range(0, 1)));
                    busy_all &= busy;
                end
            end
        end
        step(1'b1, pbit);
        busy_all &= busy;
        for (int g = 0; g < stop_gap; g++) begin
            step(1'b0, 1'($urandom_range(0, 1)));
            busy_all &= busy;
        end
        step(1'b1, sbit);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b1);
        checks++;
        if (data_out !== '0 || data_vld !== 1'b0 || parity_err !== 1'b0 ||
            frame_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: data_out=%h vld=%b perr=%b ferr=%b busy=%b, required all 0",
                     data_out, data_vld, parity_err, frame_err, busy);
        end
    endtask

    task automatic test_good_frame();
        logic ba;
        send_frame(8'hA5, good_parity(8'hA5), 1'b1, -1, 0, 0, ba);
        checks++;
        if (ba !== 1'b1) begin errors++; $display("FAIL good_busy: busy_all=%b required 1", ba); end
        checks++;
        if (data_vld !== 1'b1 || parity_err !== 1'b0 || frame_err !== 1'b0 || data_out !== 8'hA5) begin
            errors++;
            $display("FAIL good_frame: vld=%b perr=%b ferr=%b data=%h, required 1 0 0 a5",
                     data_vld, parity_err, frame_err, data_out);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_low: busy=%b required 0", busy); end
        step(1'b1, 1'b1);
        checks++;
        if (data_vld !== 1'b0 || data_out !== 8'hA5) begin
            errors++;
            $display("FAIL good_pulse_width: vld=%b data=%h, required 0 a5", data_vld, data_out);
        end
    endtask

    task automatic test_parity_err();
        logic ba;
        send_frame(8'hA5, ~good_parity(8'hA5), 1'b1, -1, 0, 0, ba);
        checks++;
        if (data_vld !== 1'b1 || parity_err !== 1'b1 || data_out !== 8'hA5) begin
            errors++;
            $display("FAIL parity_err: vld=%b perr=%b data=%h, required 1 1 a5",
                     data_vld, parity_err, data_out);
        end
        step(1'b1, 1'b1);
        checks++;
        if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_err_width: perr=%b required 0", parity_err); end
    endtask

    task automatic test_frame_err();
        logic ba;
        send_frame(8'h3C, good_parity(8'h3C), 1'b0, -1, 0, 0, ba);
        checks++;
        if (frame_err !== 1'b1 || data_vld !== 1'b0 || parity_err !== 1'b0 || data_out !== 8'hA5) begin
            errors++;
            $display("FAIL frame_err: ferr=%b vld=%b perr=%b data=%h, required 1 0 0 a5",
                     frame_err, data_vld, parity_err, data_out);
        end
        step(1'b1, 1'b1);
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_err_width: ferr=%b required 0", frame_err); end
    endtask

    task automatic test_gaps();
        logic ba;
        int v0;
        v0 = vld_cnt;
        send_frame(8'h81, good_parity(8'h81), 1'b1, 3, 5, 2, ba);
        checks++;
        if (ba !== 1'b1) begin errors++; $display("FAIL gaps_busy: busy_all=%b required 1", ba); end
        checks++;
        if (data_vld !== 1'b1 || parity_err !== 1'b0 || frame_err !== 1'b0 || data_out !== 8'h81) begin
            errors++;
            $display("FAIL gaps_frame: vld=%b perr=%b ferr=%b data=%h, required 1 0 0 81",
                     data_vld, parity_err, frame_err, data_out);
        end
        checks++;
        if (vld_cnt !== v0) begin errors++; $display("FAIL gaps_early_pulse: pulses=%0d required %0d", vld_cnt - v0, 0); end
        step(1'b1, 1'b1);
    endtask

    task automatic test_mid_reset();
        logic ba;
        int v0, f0;
        v0 = vld_cnt;
        f0 = ferr_cnt;
        step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom_range(0, 1)));
        rst_n = 1'b0;
        step(1'b1, 1'b0);
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || data_out !== '0) begin
            errors++;
            $display("FAIL mid_reset_state: busy=%b data=%h, required 0 00", busy, data_out);
        end
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
        checks++;
        if (vld_cnt !== v0 || ferr_cnt !== f0 || data_out !== '0) begin
            errors++;
            $display("FAIL mid_reset_no_pulse: vld_pulses=%0d ferr_pulses=%0d data=%h, required 0 0 00",
                     vld_cnt - v0, ferr_cnt - f0, data_out);
        end
        send_frame(8'h5A, good_parity(8'h5A), 1'b1, -1, 0, 0, ba);
        checks++;
        if (data_vld !== 1'b1 || parity_err !== 1'b0 || data_out !== 8'h5A) begin
            errors++;
            $display("FAIL mid_reset_frame: vld=%b perr=%b data=%h, required 1 0 5a",
                     data_vld, parity_err, data_out);
        end
        step(1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic ba;
        int v0;
        v0 = vld_cnt;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if (busy !== 1'b0 || data_vld !== 1'b0 || frame_err !== 1'b0) begin
                errors++;
                $display("FAIL idle_line: cycle %0d busy=%b vld=%b ferr=%b, required 0 0 0",
                         i, busy, data_vld, frame_err);
            end
        end
        send_frame(8'h01, good_parity(8'h01), 1'b1, -1, 0, 0, ba);
        checks++;
        if (data_vld !== 1'b1 || data_out !== 8'h01) begin
            errors++;
            $display("FAIL b2b_first: vld=%b data=%h, required 1 01", data_vld, data_out);
        end
        send_frame(8'hFE, good_parity(8'hFE), 1'b1, -1, 0, 0, ba);
        checks++;
        if (data_vld !== 1'b1 || parity_err !== 1'b0 || data_out !== 8'hFE) begin
            errors++;
            $display("FAIL b2b_second: vld=%b perr=%b data=%h, required 1 0 fe",
                     data_vld, parity_err, data_out);
        end
        step(1'b1, 1'b1);
        checks++;
        if (vld_cnt - v0 !== 2 || last_vld_cyc - prev_vld_cyc !== DW + 3) begin
            errors++;
            $display("FAIL b2b_spacing: pulses=%0d spacing=%0d, required 2 %0d",
                     vld_cnt - v0, last_vld_cyc - prev_vld_cyc, DW + 3);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_data;
        logic [DW-1:0] w;
        logic          pbit, sbit, ba;
        logic          exp_vld, exp_perr, exp_ferr;
        exp_data = data_out === 8'hFE ? 8'hFE : 8'h00;
        exp_data = 8'hFE;
        for (int n = 0; n < 40; n++) begin
            w    = DW'($urandom);
            pbit = ($urandom_range(0, 3) == 0) ? ~good_parity(w) : good_parity(w);
            sbit = ($urandom_range(0, 4) != 0);
            for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                step(1'($urandom_range(0, 1)), 1'b1);
            send_frame(w, pbit, sbit, int'($urandom_range(0, DW)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 2)), ba);
            exp_vld  = sbit;
            exp_ferr = ~sbit;
            exp_perr = sbit && (((^w) ^ pbit) != PEXP);
            if (sbit) exp_data = w;
            checks++;
            if (data_vld !== exp_vld || parity_err !== exp_perr || frame_err !== exp_ferr ||
                data_out !== exp_data || busy !== 1'b0) begin
                errors++;
                $display("FAIL random_%0d: vld=%b perr=%b ferr=%b data=%h busy=%b, required %b %b %b %h 0",
                         n, data_vld, parity_err, frame_err, data_out, busy,
                         exp_vld, exp_perr, exp_ferr, exp_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_err();
        test_frame_err();
        test_gaps();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
